imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the 64-word combinational instruction memory.
- Owns the program counter and drives the memory byte address; the memory indexes words by address>>2.
- Captures each fetched word with its PC into a small prefetch FIFO.
- Hands instructions to decode over a valid/ready handshake; supports start/halt control and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).
- DEPTH_WORDS, 64, instruction memory size in words; the fetch PC wraps past the last word.
- FIFO_DEPTH, 2, prefetch entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; IDLE/STOP -> RUN.
- halt  in  1  pulse; RUN -> STOP (stop fetching, keep draining).
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  32  new byte PC.
- imem_addr  out  32  byte address to instruction memory (= pc register).
- imem_instr  in  32  combinational memory data for imem_addr.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- busy  out  1  state==RUN.
- fault  out  1  sticky misaligned-redirect flag.

Behaviour:
Reset (synchronous):
- pc=RESET_PC, state=IDLE, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, busy=0.
- Reset asserted mid-operation discards all FIFO contents and any pending redirect.

FSM states:
- IDLE: no fetch; start -> RUN.
- RUN: fetch whenever space is available; halt -> STOP.
- STOP: no fetch, FIFO drains normally; start -> RUN.
- Same-cycle start and halt: halt wins (RUN -> STOP; IDLE/STOP stay/enter STOP).

Fetch, in RUN only:
- space = (count < FIFO_DEPTH) or (out_valid and out_ready).
- If space and no redirect, push {pc, imem_instr} at the tail.
- Next pc: pc+4, except pc == 4*(DEPTH_WORDS-1) gives next pc = 0 (wrap).
- pc[1:0] is always 00.

Output:
- out_* show the FIFO head; out_valid = (count != 0).
- Pop on out_valid and out_ready.
- Push and pop may occur in the same cycle; count is unchanged.
- Latency: start seen at edge N, RUN from N+1, first push at edge N+1, out_valid=1 in cycle N+2 (pc=RESET_PC).
- Throughput is one instruction per cycle with out_ready held high.

Redirect (any state except IDLE; ignored in IDLE):
- Aligned (redirect_pc[1:0]==0): a pop in the same cycle completes as a valid handshake, then the FIFO is flushed (count=0).
- Aligned redirect also loads pc=redirect_pc and suppresses that cycle's push. State unchanged; in STOP the pc updates but no fetch occurs.
- Misaligned: fault<=1, state<=STOP, pc unchanged, FIFO not flushed.
- fault clears only on reset; start from STOP with fault=1 still resumes RUN.
- redirect has priority over push; halt in the same cycle as a redirect applies both.

FIFO:
- Full (count==FIFO_DEPTH) with no pop: no fetch, pc holds.
- Empty: out_valid=0; out_instr/out_pc hold their last values (don't-care).

Test Plan:
1. Reset, memory words k = 32'h1000_0000+k, start pulse, out_ready=1 -> out_valid rises 2 cycles after start; stream 0x10000000,0x10000001,… with out_pc 0,4,8,…, one per cycle.
2. out_ready=0 after start -> count saturates at 2, imem_addr holds at 8. Then out_ready=1 -> entries pc=0,4 delivered, then pc=8, no gaps or duplicates.
3. Redirect to 0x40 while FIFO holds pc 8,12 and out_ready=1 -> pc 8 consumed, 12 dropped; next delivered out_pc=0x40, instr 0x10000010.
4. Redirect to 0x42 -> fault=1, busy=0, pc unchanged, buffered entries still drain; start -> busy=1, fault stays 1.
5. Redirect to 0xFC, run -> out_pc 0xFC then 0x00 (wrap).
6. halt and start in the same cycle while RUN -> STOP, no new pushes. Then assert reset mid-drain -> out_valid=0 next cycle, imem_addr=RESET_PC, state IDLE.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer sitting in front of a combinational instruction
// memory. It owns the program counter, presents it as the memory byte address,
// captures each fetched word together with its PC into a small prefetch FIFO,
// and hands the FIFO head to decode over a valid/ready handshake.
// Start/halt pulses move the sequencer between IDLE, RUN and STOP. A
// branch/jump redirect flushes the prefetch FIFO and reloads the PC. A
// misaligned redirect target raises a sticky fault and stops fetching.
//
// Ports:
//   clk             in   1   clock, all state updates on the rising edge
//   reset           in   1   synchronous, active-high reset
//   start           in   1   pulse: IDLE/STOP -> RUN
//   halt            in   1   pulse: RUN -> STOP (fetch stops, FIFO drains)
//   redirect_valid  in   1   taken branch/jump: flush and reload the PC
//   redirect_pc     in  32   new byte PC for the redirect
//   imem_addr       out 32   byte address to the instruction memory (= pc)
//   imem_instr      in  32   combinational memory data for imem_addr
//   out_valid       out  1   FIFO head is valid
//   out_ready       in   1   decode accepts the head
//   out_instr       out 32   head instruction
//   out_pc          out 32   head PC
//   busy            out  1   sequencer is in RUN
//   fault           out  1   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  // Byte address of the last memory word; fetching past it wraps to 0.
  localparam logic [31:0]      LAST_PC   = 32'(4 * (DEPTH_WORDS - 1));
  // The PC is kept word aligned even if the parameter is not.
  localparam logic [31:0]      START_PC  = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_r;
  state_t            state_s;
  logic [31:0]       pc_r;
  logic [31:0]       pc_s;
  logic              fault_r;
  logic              fault_s;

  logic [31:0]       fifo_pc_r    [FIFO_DEPTH];
  logic [31:0]       fifo_instr_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions
  // ---------------------------------------------------------------------------
  logic              pop_s;
  logic              space_s;
  logic              redir_s;
  logic              redir_ok_s;
  logic              redir_bad_s;
  logic              push_s;

  // Sequential PC step with wrap at the end of the instruction memory.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    logic [31:0] nxt;
    if (pc == LAST_PC) begin
      nxt = 32'h0000_0000;
    end else begin
      nxt = pc + 32'd4;
    end
    return nxt;
  endfunction

  // Handshake, redirect qualification and fetch decision for this cycle.
  always_comb begin
    pop_s       = 1'b0;
    space_s     = 1'b0;
    redir_s     = 1'b0;
    redir_ok_s  = 1'b0;
    redir_bad_s = 1'b0;
    push_s      = 1'b0;

    pop_s = (count_r != CNT_ZERO) && out_ready;

    // Redirects are ignored until the sequencer has been started once.
    if (state_r != ST_IDLE) begin
      redir_s = redirect_valid;
    end else begin
      redir_s = 1'b0;
    end

    redir_ok_s  = redir_s && (redirect_pc[1:0] == 2'b00);
    redir_bad_s = redir_s && (redirect_pc[1:0] != 2'b00);

    // A slot frees up either because the FIFO is not full or because the
    // head leaves this same cycle.
    space_s = (count_r < FULL_CNT) || pop_s;

    // A redirect (good or bad) always takes priority over fetching.
    if (state_r == ST_RUN) begin
      push_s = space_s && !redir_s;
    end else begin
      push_s = 1'b0;
    end
  end

  // Next sequencer state, PC and fault flag.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    fault_s = fault_r;

    case (state_r)
      ST_IDLE: begin
        // Simultaneous start and halt resolves to halt.
        if (start && halt) begin
          state_s = ST_STOP;
        end else if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STOP: begin
        // A pending fault does not block restarting.
        if (start && !halt) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A misaligned target is unusable: stop fetching, remember the fault.
    if (redir_bad_s) begin
      state_s = ST_STOP;
      fault_s = 1'b1;
    end else begin
      fault_s = fault_r;
    end

    if (redir_ok_s) begin
      pc_s = redirect_pc;
    end else if (push_s) begin
      pc_s = next_seq_pc(pc_r);
    end else begin
      pc_s = pc_r;
    end
  end

  // Sequencer state, PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= START_PC;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      fault_r <= fault_s;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]    <= 32'h0000_0000;
        fifo_instr_r[i] <= 32'h0000_0000;
      end
    end else if (redir_ok_s) begin
      // Any same-cycle pop has already been accepted by decode; the flush
      // simply discards whatever remains.
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_pc_r[tail_r]    <= pc_r;
        fifo_instr_r[tail_r] <= imem_instr;
        tail_r               <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end

      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken directly from registers. When the FIFO is empty the
  // head slot still holds stale data, which decode must ignore.
  // ---------------------------------------------------------------------------
  assign imem_addr = pc_r;
  assign out_valid = (count_r != CNT_ZERO);
  assign out_instr = fifo_instr_r[head_r];
  assign out_pc    = fifo_pc_r[head_r];
  assign busy      = (state_r == ST_RUN);
  assign fault     = fault_r;

endmodule
